// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard inputs and stage register controls
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic                      id_rs1_ren;
  logic                      id_rs2_ren;
  logic                      ex_valid;
  logic                      ex_mem_ren;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr;
  logic                      ex_redirect;
  logic                      mem_req;
  logic                      mem_resp;

  logic pc_en;
  logic if_id_en;
  logic id_exe_en;
  logic exe_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_exe_flush;
  logic mem_wb_flush;

  // Pipeline side: presents stage status, consumes stage controls
  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
    output ex_valid, ex_mem_ren, ex_reg_waddr, ex_redirect, mem_req, mem_resp,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
    input  if_id_flush, id_exe_flush, mem_wb_flush
  );

  // Controller side: consumes stage status, drives stage controls
  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
    input  ex_valid, ex_mem_ren, ex_reg_waddr, ex_redirect, mem_req, mem_resp,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
    output if_id_flush, id_exe_flush, mem_wb_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline stall/flush controller with memory watchdog
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_ctrl_if.slave         bus,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0]   wait_inc;
  logic                halt_q, halt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic mem_block;
  logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic if_id_flush, id_exe_flush, mem_wb_flush;

  // Hazard detection: a load in EX feeding a register ID is about to read
  always_comb begin
    lu = bus.id_valid && bus.ex_valid && bus.ex_mem_ren &&
         (bus.ex_reg_waddr != '0) &&
         ((bus.id_rs1_ren && (bus.id_rs1_addr == bus.ex_reg_waddr)) ||
          (bus.id_rs2_ren && (bus.id_rs2_addr == bus.ex_reg_waddr)));
    mem_block = bus.mem_req && !bus.mem_resp;
    wait_inc  = wait_cnt_q + WAIT_ONE;
  end

  // Next-state and stage controls; resolve path shared by RUN and MEM_WAIT response
  always_comb begin
    logic resolve;
    logic stall_mem;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    resolve      = 1'b0;
    stall_mem    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_exe_en    = 1'b1;
    exe_mem_en   = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    mem_wb_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_block) begin
          stall_mem  = 1'b1;
          wait_cnt_d = WAIT_ONE;
          state_d    = (WAIT_ONE >= WAIT_MAX) ? ERROR : MEM_WAIT;
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_resp) begin
          stall_mem  = 1'b1;
          wait_cnt_d = wait_inc;
          if (wait_inc >= WAIT_MAX) state_d = ERROR;
        end else begin
          resolve    = 1'b1;
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end
      default: begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_exe_en  = 1'b0;
        exe_mem_en = 1'b0;
        mem_wb_en  = 1'b0;
        state_d    = ERROR;
      end
    endcase

    // MEM holds its instruction; WB is fed a bubble so nothing retires twice
    if (stall_mem) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_en    = 1'b0;
      exe_mem_en   = 1'b0;
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end

    // Redirect squashes the ID instruction, so a coincident load-use is moot
    if (resolve) begin
      if (bus.ex_redirect) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (lu) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
      end
    end

    // Reset forces every control low without waiting for a clock
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_en    = 1'b0;
      exe_mem_en   = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  // Performance counters and sticky halt
  always_comb begin
    halt_d      = halt_q || (state_d == ERROR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ERROR) && !pc_en) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (if_id_flush)                  flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_exe_en    = id_exe_en;
  assign bus.exe_mem_en   = exe_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_exe_flush = id_exe_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign halt             = halt_q;
  assign stall_cnt        = stall_cnt_q;
  assign flush_cnt        = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage NPC core: it sequences the pipeline registers that feed the forwarding datapath. Each cycle it decides which stage registers advance, hold or take a bubble. It resolves load-use hazards that forwarding cannot cover, EX-stage redirects and multi-cycle data-memory waits. It also keeps stall/flush performance counters and a memory-wait watchdog that halts the core on timeout.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register-file address width
- MEM_TIMEOUT, 255, max consecutive wait cycles before the watchdog trips
- CNT_WIDTH, 32, perf counter width

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- id_valid  input  1  ID stage holds a valid instruction
- id_rs1_addr / id_rs2_addr  input  REG_ADDR_WIDTH  ID source registers
- id_rs1_ren / id_rs2_ren  input  1  ID source actually read
- ex_valid  input  1  EX stage holds a valid instruction
- ex_mem_ren  input  1  EX instruction is a load
- ex_reg_waddr  input  REG_ADDR_WIDTH  EX destination register
- ex_redirect  input  1  EX resolved a taken branch/jump
- mem_req  input  1  MEM stage instruction needs data memory this cycle
- mem_resp  input  1  data memory response/ack valid
- pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  output  1 each  stage register load enables
- if_id_flush, id_exe_flush, mem_wb_flush  output  1 each  load a bubble (valid=0) instead of data
- halt  output  1  sticky watchdog error
- stall_cnt  output  CNT_WIDTH  cycles with pc_en=0 while not halted
- flush_cnt  output  CNT_WIDTH  accepted redirects

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Load-use hazard (lu) when all of the following hold:
  - id_valid && ex_valid && ex_mem_ren && ex_reg_waddr!=0
  - (id_rs1_ren && id_rs1_addr==ex_reg_waddr) || (id_rs2_ren && id_rs2_addr==ex_reg_waddr)
- mem_block = mem_req && !mem_resp.
- RUN, default: all enables 1, all flushes 0.
- RUN with mem_block:
  - all enables 0 except mem_wb_en=1 with mem_wb_flush=1
  - next state MEM_WAIT; wait counter loads 1
  - redirect and lu are ignored this cycle; EX holds, so they re-present later.
- RUN with ex_redirect (no mem_block):
  - pc_en=1 (PC takes the target), if_id_flush=1, id_exe_flush=1
  - flush_cnt+1
  - lu is ignored because the ID instruction is squashed.
- RUN with lu (no mem_block, no redirect):
  - pc_en=0, if_id_en=0, id_exe_flush=1
  - exe_mem_en=1, mem_wb_en=1
- MEM_WAIT with !mem_resp:
  - outputs as in the RUN mem_block case
  - wait counter +1
  - counter reaching MEM_TIMEOUT goes to ERROR.
- MEM_WAIT with mem_resp:
  - outputs evaluated exactly as RUN with mem_block=0 (redirect, then lu, then default)
  - next state RUN; wait counter cleared.
- ERROR: all enables 0, all flushes 0, halt=1. Only reset leaves ERROR.
- Priority: ERROR > mem_block > ex_redirect > lu > default.
- Counters:
  - stall_cnt increments on every non-ERROR cycle with pc_en=0.
  - flush_cnt increments on every cycle with if_id_flush=1.
  - Both counters wrap modulo 2^CNT_WIDTH.
- Wait counter width is clog2(MEM_TIMEOUT+1).

## Timing
- All enable/flush outputs are combinational from the current state and inputs (same-cycle stall, zero added latency).
- State, wait counter, halt, stall_cnt and flush_cnt are registered and update on the rising clk edge.
- rst_n low, asynchronously:
  - state=RUN, wait counter=0, halt=0, stall_cnt=0, flush_cnt=0
  - all enables forced 0, all flushes forced 0
- rst_n deassertion: the first clk edge runs RUN logic. Reset during MEM_WAIT or ERROR returns to RUN with no residue.
- Zero-wait access: mem_req && mem_resp in the same cycle never enters MEM_WAIT.
- Load-use stall is exactly 1 cycle when memory is zero-wait. It is extended only by MEM_WAIT.
- Watchdog: with mem_req=1 and mem_resp=0 held from cycle 0, halt rises after the edge of cycle MEM_TIMEOUT-1. A response on that same edge wins: go to RUN, no halt.

## Test plan
- Load-use hazard:
  - stimulus: ex_mem_ren=1, ex_reg_waddr=5, id_rs2_addr=5, id_rs2_ren=1, zero-wait memory
  - response: one cycle with pc_en=0, if_id_en=0, id_exe_flush=1; stall_cnt=1
  - repeat with ex_reg_waddr=0: no stall.
- Redirect with hazard:
  - stimulus: ex_redirect=1 together with a lu condition
  - response: pc_en=1, if_id_flush=1, id_exe_flush=1, no stall; flush_cnt=1.
- Memory wait:
  - stimulus: mem_req=1, mem_resp=0 for 3 cycles, then mem_resp=1
  - response: 3 cycles with enables 0 and mem_wb_flush=1, then a normal cycle; stall_cnt=3; state back in RUN.
- Redirect held during wait:
  - stimulus: ex_redirect=1 asserted throughout a 2-cycle memory wait
  - response: no flush while waiting; the flush fires once, on the mem_resp cycle; flush_cnt=1.
- Watchdog:
  - stimulus: MEM_TIMEOUT=4, mem_req=1, no response
  - response: halt=1 after the 4th edge, all enables 0 thereafter; rst_n pulse clears halt and both counters.
- Asynchronous reset:
  - stimulus: assert rst_n=0 mid-MEM_WAIT between clock edges
  - response: outputs go to reset values immediately; normal RUN resumes after release.
